// File: rtl/sccb_config_seq.sv
// Walks the camera register-init ROM and turns each entry into a
// 4-byte SCCB write. Handles delay entries, the end marker and NACK retry.
module sccb_config_seq #(
  parameter int         MAIN_CLOCK = 25_000_000,
  parameter logic [7:0] DEV_ADDR   = 8'h78,
  parameter int         ROM_AW     = 8,
  parameter int         POWERUP_MS = 20,
  parameter int         GAP_CYCLES = 64,
  parameter int         RETRY_MAX  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [23:0]       rom_data,
  output logic              i2c_start,
  output logic              i2c_stop,
  output logic [7:0]        i2c_wr_data,
  input  logic [1:0]        i2c_ack,
  input  logic [3:0]        i2c_state,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [7:0]        nack_count
);

  localparam logic [31:0] CYC_PER_MS = 32'(MAIN_CLOCK / 1000);
  localparam logic [31:0] PWRUP_CYC =
    32'(POWERUP_MS * (MAIN_CLOCK / 1000));
  localparam logic [31:0] GAP_CYC = 32'(GAP_CYCLES);
  localparam logic [7:0]  RMAX = 8'(RETRY_MAX);

  typedef enum logic [3:0] {
    S_IDLE,
    S_PWRUP,
    S_FETCH,
    S_DECODE,
    S_DELAY,
    S_ISSUE,
    S_WAIT_ACK,
    S_DRAIN,
    S_GAP
  } state_t;

  state_t            state, state_n;
  logic [31:0]       cnt, cnt_n;
  logic [23:0]       entry, entry_n;
  logic [1:0]        byte_cnt, byte_cnt_n;
  logic              nack_flag, nack_flag_n;
  logic [7:0]        retry, retry_n;
  logic [ROM_AW-1:0] rom_addr_n;
  logic              stop_n;
  logic              busy_n, done_n, error_n;
  logic [7:0]        nack_count_n;
  logic              adv;
  logic              is_end, is_delay, bus_idle, last_addr;

  assign is_end    = (rom_data == 24'hFFFFFF);
  assign is_delay  = (rom_data[23:8] == 16'hFFFF) && !is_end;
  assign bus_idle  = (i2c_state == 4'd0);
  assign last_addr = &rom_addr;

  // start is only ever raised combinationally against an idle master
  assign i2c_start = (state == S_ISSUE) && bus_idle;

  always_comb begin
    i2c_wr_data = 8'h00;
    if (state == S_ISSUE) begin
      i2c_wr_data = DEV_ADDR;
    end else if (state == S_WAIT_ACK) begin
      unique case (byte_cnt)
        2'd0:    i2c_wr_data = entry[23:16];
        2'd1:    i2c_wr_data = entry[15:8];
        default: i2c_wr_data = entry[7:0];
      endcase
    end
  end

  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    entry_n      = entry;
    byte_cnt_n   = byte_cnt;
    nack_flag_n  = nack_flag;
    retry_n      = retry;
    rom_addr_n   = rom_addr;
    busy_n       = busy;
    done_n       = 1'b0;
    error_n      = error;
    nack_count_n = nack_count;
    adv          = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (go) begin
          busy_n       = 1'b1;
          rom_addr_n   = '0;
          error_n      = 1'b0;
          nack_count_n = 8'h00;
          retry_n      = 8'h00;
          nack_flag_n  = 1'b0;
          cnt_n        = PWRUP_CYC;
          state_n      = S_PWRUP;
        end
      end
      S_PWRUP: begin
        if (cnt <= 32'd1) state_n = S_FETCH;
        else              cnt_n   = cnt - 32'd1;
      end
      S_FETCH: state_n = S_DECODE;
      S_DECODE: begin
        if (is_end) begin
          done_n  = 1'b1;
          busy_n  = 1'b0;
          state_n = S_IDLE;
        end else if (is_delay) begin
          cnt_n   = 32'(rom_data[7:0]) * CYC_PER_MS;
          state_n = S_DELAY;
        end else begin
          entry_n = rom_data;
          state_n = S_ISSUE;
        end
      end
      S_DELAY: begin
        if (cnt == 32'd0) adv   = 1'b1;
        else              cnt_n = cnt - 32'd1;
      end
      S_ISSUE: begin
        if (bus_idle) begin
          byte_cnt_n = 2'd0;
          state_n    = S_WAIT_ACK;
        end
      end
      S_WAIT_ACK: begin
        if (i2c_ack[1]) begin
          if (!i2c_ack[0]) nack_flag_n = 1'b1;
          if (byte_cnt == 2'd3) state_n    = S_DRAIN;
          else                  byte_cnt_n = byte_cnt + 2'd1;
        end
      end
      S_DRAIN: begin
        if (bus_idle) begin
          nack_flag_n = 1'b0;
          if (nack_flag && nack_count != 8'hFF)
            nack_count_n = nack_count + 8'd1;
          if (!nack_flag) begin
            retry_n = 8'h00;
            adv     = 1'b1;
          end else if (retry < RMAX) begin
            retry_n = retry + 8'd1;
            cnt_n   = GAP_CYC;
            state_n = S_GAP;
          end else begin
            error_n = 1'b1;
            retry_n = 8'h00;
            adv     = 1'b1;
          end
        end
      end
      S_GAP: begin
        if (cnt <= 32'd1) state_n = S_FETCH;
        else              cnt_n   = cnt - 32'd1;
      end
      default: state_n = S_IDLE;
    endcase

    // moving past the last ROM slot without an end marker aborts the run
    if (adv) begin
      if (last_addr) begin
        error_n = 1'b1;
        done_n  = 1'b1;
        busy_n  = 1'b0;
        state_n = S_IDLE;
      end else begin
        rom_addr_n = rom_addr + 1'b1;
        if (state == S_DRAIN) begin
          cnt_n   = GAP_CYC;
          state_n = S_GAP;
        end else begin
          state_n = S_FETCH;
        end
      end
    end

    stop_n = (state_n == S_WAIT_ACK) && (byte_cnt_n == 2'd3);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= 32'd0;
      entry      <= 24'h0;
      byte_cnt   <= 2'd0;
      nack_flag  <= 1'b0;
      retry      <= 8'h00;
      rom_addr   <= '0;
      i2c_stop   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      nack_count <= 8'h00;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      entry      <= entry_n;
      byte_cnt   <= byte_cnt_n;
      nack_flag  <= nack_flag_n;
      retry      <= retry_n;
      rom_addr   <= rom_addr_n;
      i2c_stop   <= stop_n;
      busy       <= busy_n;
      done       <= done_n;
      error      <= error_n;
      nack_count <= nack_count_n;
    end
  end

endmodule

// File: tb/tb_sccb_config_seq.sv
// Directed bench for sccb_config_seq: sync ROM plus a small
// SCCB master/slave model that logs bytes and can NACK a chosen entry.
module tb_sccb_config_seq;

  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          go;
  logic [AW-1:0] rom_addr;
  logic [23:0]   rom_data;
  logic          i2c_start;
  logic          i2c_stop;
  logic [7:0]    i2c_wr_data;
  logic [1:0]    i2c_ack;
  logic [3:0]    i2c_state;
  logic          busy;
  logic          done;
  logic          error;
  logic [7:0]    nack_count;

  int n_chk = 0;
  int n_fail = 0;

  logic [23:0] rom [4];

  sccb_config_seq #(
    .MAIN_CLOCK (10_000),
    .DEV_ADDR   (8'h78),
    .ROM_AW     (AW),
    .POWERUP_MS (2),
    .GAP_CYCLES (8),
    .RETRY_MAX  (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .go          (go),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .i2c_start   (i2c_start),
    .i2c_stop    (i2c_stop),
    .i2c_wr_data (i2c_wr_data),
    .i2c_ack     (i2c_ack),
    .i2c_state   (i2c_state),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .nack_count  (nack_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[rom_addr];

  // master/slave model
  logic [1:0]  mst;
  int          mcnt;
  int          nb;
  logic [7:0]  t_hi, t_lo;
  logic [7:0]  nk_hi, nk_lo;
  int          nack_budget;
  int          nack_used = 0;
  logic [7:0]  bq[$];
  int          start_t[$];
  int          stop_t[$];
  int          cyc = 0;
  int          start_viol = 0;
  int          stop_bad = 0;
  int          done_hi = 0;

  assign i2c_state = {2'b00, mst};

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (done) done_hi <= done_hi + 1;
    if (i2c_start && mst != 2'd0) start_viol <= start_viol + 1;
    if (rst) begin
      mst     <= 2'd0;
      i2c_ack <= 2'b00;
      mcnt    <= 0;
      nb      <= 0;
    end else begin
      i2c_ack <= 2'b00;
      case (mst)
        2'd0: begin
          if (i2c_start) begin
            bq.push_back(i2c_wr_data);
            start_t.push_back(cyc);
            mst  <= 2'd1;
            mcnt <= 4;
            nb   <= 0;
          end
        end
        2'd1: begin
          if (i2c_ack[1]) begin
            nb   <= nb + 1;
            mcnt <= 4;
            if (nb == 0) t_hi <= i2c_wr_data;
            if (nb == 1) t_lo <= i2c_wr_data;
            if (nb == 3) begin
              if (!i2c_stop) stop_bad <= stop_bad + 1;
              stop_t.push_back(cyc);
              mst  <= 2'd2;
              mcnt <= 3;
            end else begin
              bq.push_back(i2c_wr_data);
              if (i2c_stop) stop_bad <= stop_bad + 1;
            end
          end else if (mcnt == 0) begin
            if (nb == 3 && t_hi == nk_hi && t_lo == nk_lo &&
                nack_used < nack_budget) begin
              i2c_ack   <= 2'b10;
              nack_used <= nack_used + 1;
            end else begin
              i2c_ack <= 2'b11;
            end
          end else begin
            mcnt <= mcnt - 1;
          end
        end
        default: begin
          if (mcnt == 0) mst  <= 2'd0;
          else           mcnt <= mcnt - 1;
        end
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pulse_go(output int g);
    @(negedge clk);
    go = 1'b1;
    g  = cyc;
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_bytes(input string tag, input int n);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (bq.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic chk_txn(input string tag, input int idx,
                         input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c);
    chk({tag, "_dev"}, 32'(bq[idx]), 32'h78);
    chk({tag, "_hi"},  32'(bq[idx+1]), 32'(a));
    chk({tag, "_lo"},  32'(bq[idx+2]), 32'(b));
    chk({tag, "_dat"}, 32'(bq[idx+3]), 32'(c));
  endtask

  int g, b0, s0, p0, d0, dt;

  initial begin
    rst = 1'b1;
    go  = 1'b0;
    nk_hi = 8'h00;
    nk_lo = 8'h00;
    nack_budget = 0;
    for (int i = 0; i < 4; i++) rom[i] = 24'h0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_addr", 32'(rom_addr), 32'd0);
    chk("rst_start", 32'(i2c_start), 32'd0);
    chk("rst_stop", 32'(i2c_stop), 32'd0);
    chk("rst_nack", 32'(nack_count), 32'd0);
    chk("rst_wdata", 32'(i2c_wr_data), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 1: single write then end marker
    rom[0] = 24'h300A56;
    rom[1] = 24'hFFFFFF;
    b0 = bq.size(); s0 = start_t.size(); d0 = done_hi;
    pulse_go(g);
    chk("t1_busy", 32'(busy), 32'd1);
    wait_done("t1");
    chk("t1_err", 32'(error), 32'd0);
    chk("t1_busy_end", 32'(busy), 32'd0);
    chk("t1_nack", 32'(nack_count), 32'd0);
    chk("t1_nbytes", 32'(bq.size() - b0), 32'd4);
    chk_txn("t1", b0, 8'h30, 8'h0A, 8'h56);
    dt = start_t[s0] - g;
    chk("t1_pwrup", 32'(dt >= 20 && dt <= 26), 32'd1);
    repeat (3) @(negedge clk);
    chk("t1_done_w", 32'(done_hi - d0), 32'd1);

    // 2: delay entry between two writes
    rom[0] = 24'h300A56;
    rom[1] = 24'hFFFF05;
    rom[2] = 24'h12349A;
    rom[3] = 24'hFFFFFF;
    b0 = bq.size(); s0 = start_t.size(); p0 = stop_t.size();
    pulse_go(g);
    wait_done("t2");
    chk("t2_starts", 32'(start_t.size() - s0), 32'd2);
    chk_txn("t2a", b0, 8'h30, 8'h0A, 8'h56);
    chk_txn("t2b", b0 + 4, 8'h12, 8'h34, 8'h9A);
    dt = start_t[s0+1] - stop_t[p0];
    chk("t2_delay", 32'(dt >= 50), 32'd1);
    chk("t2_err", 32'(error), 32'd0);

    // 3: entry NACKed on every try gets skipped
    rom[0] = 24'h310311;
    rom[1] = 24'h400022;
    rom[2] = 24'hFFFFFF;
    nk_hi = 8'h31; nk_lo = 8'h03;
    nack_budget = nack_used + 4;
    b0 = bq.size(); s0 = start_t.size();
    pulse_go(g);
    wait_done("t3");
    chk("t3_starts", 32'(start_t.size() - s0), 32'd5);
    chk("t3_nack", 32'(nack_count), 32'd4);
    chk("t3_err", 32'(error), 32'd1);
    chk_txn("t3r", b0 + 12, 8'h31, 8'h03, 8'h11);
    chk_txn("t3n", b0 + 16, 8'h40, 8'h00, 8'h22);

    // 4: one NACK then ACK
    nack_budget = nack_used + 1;
    b0 = bq.size(); s0 = start_t.size();
    pulse_go(g);
    wait_done("t4");
    chk("t4_starts", 32'(start_t.size() - s0), 32'd3);
    chk("t4_nack", 32'(nack_count), 32'd1);
    chk("t4_err", 32'(error), 32'd0);
    chk_txn("t4r", b0 + 4, 8'h31, 8'h03, 8'h11);
    nack_budget = nack_used;

    // 5: reset in the middle of the second entry
    rom[0] = 24'h300A56;
    rom[1] = 24'h500033;
    rom[2] = 24'hFFFFFF;
    b0 = bq.size();
    pulse_go(g);
    wait_bytes("t5_mid", b0 + 6);
    chk("t5_addr_pre", 32'(rom_addr), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_start", 32'(i2c_start), 32'd0);
    chk("t5_stop", 32'(i2c_stop), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_addr", 32'(rom_addr), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    b0 = bq.size();
    pulse_go(g);
    wait_done("t5");
    chk("t5_nbytes", 32'(bq.size() - b0), 32'd8);
    chk_txn("t5r", b0, 8'h30, 8'h0A, 8'h56);

    // 6: no end marker, second go while busy
    rom[0] = 24'h010101;
    rom[1] = 24'h020202;
    rom[2] = 24'h030303;
    rom[3] = 24'h040404;
    b0 = bq.size(); s0 = start_t.size();
    pulse_go(g);
    wait_bytes("t6_mid", b0 + 6);
    pulse_go(g);
    wait_done("t6");
    chk("t6_err", 32'(error), 32'd1);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_starts", 32'(start_t.size() - s0), 32'd4);
    chk_txn("t6a", b0, 8'h01, 8'h01, 8'h01);
    chk_txn("t6d", b0 + 12, 8'h04, 8'h04, 8'h04);

    repeat (10) @(negedge clk);
    chk("start_viol", 32'(start_viol), 32'd0);
    chk("stop_level", 32'(stop_bad), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
